// File: rtl/serial_binary_adder_subtractor.sv
// Multi-cycle two's-complement adder/subtractor: CHUNK bits per clock, valid/ready on both sides.
// Optional build macro ADDSUB_SATURATE_EN forces S to signed saturation on overflow.
module serial_binary_adder_subtractor #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             M,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             V
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] opa, opb;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [CHUNK:0]   csum;
  logic             last_chunk;
  logic             v_nxt;
  logic [WIDTH-1:0] full;
  logic [WIDTH-1:0] s_final;

  assign csum       = {1'b0, opa[CHUNK-1:0]} + {1'b0, opb[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry};
  assign last_chunk = (cnt == LAST);
  // Carry into the chunk MSB is recovered from the sum bit: s = a ^ b ^ cin.
  assign v_nxt      = csum[CHUNK] ^ (csum[CHUNK-1] ^ opa[CHUNK-1] ^ opb[CHUNK-1]);

  generate
    if (NCHUNK > 1) begin : g_acc
      logic [WIDTH-CHUNK-1:0] acc;
      assign full = {csum[CHUNK-1:0], acc};
      always_ff @(posedge CLK) begin
        if (!RST_N)
          acc <= '0;
        else if (state == RUN)
          acc <= full[WIDTH-1:CHUNK];
      end
    end else begin : g_noacc
      assign full = csum[CHUNK-1:0];
    end
  endgenerate

`ifdef ADDSUB_SATURATE_EN
  logic a_msb;

  function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] val,
                                                input logic ovf, input logic neg);
    if (!ovf)
      return val;
    return neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  endfunction

  always_ff @(posedge CLK) begin
    if (!RST_N)
      a_msb <= 1'b0;
    else if (state == IDLE && IN_VALID)
      a_msb <= A[WIDTH-1];
  end

  assign s_final = saturate(full, v_nxt, a_msb);
`else
  assign s_final = full;
`endif

  always_ff @(posedge CLK) begin
    if (!RST_N)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    IN_READY  = 1'b0;
    OUT_VALID = 1'b0;
    case (state)
      IDLE: begin
        IN_READY = 1'b1;
        if (IN_VALID)
          state_nxt = RUN;
      end
      RUN: begin
        if (last_chunk)
          state_nxt = DONE;
      end
      DONE: begin
        OUT_VALID = 1'b1;
        if (OUT_READY)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Result registers update only on the final chunk so S never shows a partial sum.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      opa   <= '0;
      opb   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      S     <= '0;
      Cout  <= 1'b0;
      V     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (IN_VALID) begin
            opa   <= A;
            opb   <= B ^ {WIDTH{M}};
            carry <= M;
            cnt   <= '0;
          end
        end
        RUN: begin
          opa   <= opa >> CHUNK;
          opb   <= opb >> CHUNK;
          carry <= csum[CHUNK];
          cnt   <= cnt + CW'(1);
          if (last_chunk) begin
            S    <= s_final;
            Cout <= csum[CHUNK];
            V    <= v_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_binary_adder_subtractor.sv
// Directed bench for serial_binary_adder_subtractor (16/4 instance plus a 16/16 single-chunk instance).
module tb_serial_binary_adder_subtractor;

`ifdef ADDSUB_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        IN_VALID = 1'b0, IN_READY, M = 1'b0, OUT_VALID, OUT_READY = 1'b0, Cout, V;
  logic [15:0] A = '0, B = '0, S;
  logic        iv2 = 1'b0, ir2, m2 = 1'b0, ov2, or2 = 1'b0, c2, v2;
  logic [15:0] a2 = '0, b2 = '0, s2;

  int          total = 0;
  int          bad = 0;
  logic        mon_en = 1'b0;
  logic [15:0] exp_s = '0, shown_s = '0;
  logic        exp_c = 1'b0, exp_v = 1'b0, shown_c = 1'b0, shown_v = 1'b0;

  always #5 CLK = ~CLK;

  serial_binary_adder_subtractor #(.WIDTH(16), .CHUNK(4)) dut (
    .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .A(A), .B(B), .M(M), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .S(S), .Cout(Cout), .V(V)
  );

  serial_binary_adder_subtractor #(.WIDTH(16), .CHUNK(16)) dut16 (
    .CLK(CLK), .RST_N(RST_N), .IN_VALID(iv2), .IN_READY(ir2),
    .A(a2), .B(b2), .M(m2), .OUT_VALID(ov2), .OUT_READY(or2),
    .S(s2), .Cout(c2), .V(v2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Plain integer arithmetic; overflow judged from operand and result signs.
  task automatic model(input logic [15:0] a, input logic [15:0] b, input logic m,
                       output logic [15:0] s, output logic c, output logic v);
    logic [16:0] fullsum;
    fullsum = m ? ({1'b0, a} - {1'b0, b} + 17'h10000) : ({1'b0, a} + {1'b0, b});
    s = fullsum[15:0];
    c = fullsum[16];
    v = m ? (a[15] != b[15] && s[15] != a[15]) : (a[15] == b[15] && s[15] != a[15]);
    if (SAT && v)
      s = a[15] ? 16'h8000 : 16'h7FFF;
  endtask

  always @(negedge CLK) begin
    if (mon_en) begin
      if (OUT_VALID) begin
        chk("model_s", S, exp_s);
        chk("model_cout", Cout, exp_c);
        chk("model_v", V, exp_v);
        shown_s = exp_s;
        shown_c = exp_c;
        shown_v = exp_v;
      end else begin
        chk("hold_s", S, shown_s);
        chk("hold_cout", Cout, shown_c);
        chk("hold_v", V, shown_v);
      end
    end
  end

  task automatic op(input logic [15:0] a, input logic [15:0] b, input logic m,
                    input logic [15:0] ls, input logic lc, input logic lv,
                    input logic use_lit, input int hold);
    logic [15:0] ms;
    logic        mc, mv;
    int          lat;
    model(a, b, m, ms, mc, mv);
    if (use_lit) begin
      chk("pin_model_s", ms, ls);
      chk("pin_model_cout", mc, lc);
      chk("pin_model_v", mv, lv);
    end
    @(negedge CLK);
    chk("in_ready_idle", IN_READY, 1'b1);
    A = a; B = b; M = m; IN_VALID = 1'b1;
    exp_s = ms; exp_c = mc; exp_v = mv;
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    A = 16'($urandom); B = 16'($urandom); M = 1'($urandom);
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge CLK); #1;
      if (OUT_VALID) begin
        lat = n;
        break;
      end
    end
    chk("latency", lat, 4);
    if (lat == 0) return;
    if (use_lit) begin
      chk("lit_s", S, ls);
      chk("lit_cout", Cout, lc);
      chk("lit_v", V, lv);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge CLK);
      IN_VALID = 1'b1; A = 16'($urandom); B = 16'($urandom);
      chk("busy_in_ready", IN_READY, 1'b0);
      chk("held_out_valid", OUT_VALID, 1'b1);
    end
    @(negedge CLK);
    IN_VALID = 1'b0; OUT_READY = 1'b1;
    @(posedge CLK); #1;
    OUT_READY = 1'b0;
    chk("handoff_out_valid", OUT_VALID, 1'b0);
    chk("handoff_in_ready", IN_READY, 1'b1);
  endtask

  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic m,
                      input logic [15:0] ls, input logic lc, input logic lv);
    @(negedge CLK);
    a2 = a; b2 = b; m2 = m; iv2 = 1'b1;
    @(posedge CLK); #1;
    iv2 = 1'b0;
    chk("c16_not_yet", ov2, 1'b0);
    @(posedge CLK); #1;
    chk("c16_latency1", ov2, 1'b1);
    chk("c16_s", s2, ls);
    chk("c16_cout", c2, lc);
    chk("c16_v", v2, lv);
    @(negedge CLK);
    or2 = 1'b1;
    @(posedge CLK); #1;
    or2 = 1'b0;
    chk("c16_handoff", ov2, 1'b0);
  endtask

  initial begin
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_in_ready", IN_READY, 1'b1);
    chk("rst_out_valid", OUT_VALID, 1'b0);
    chk("rst_s", S, 16'h0000);
    chk("rst_cout", Cout, 1'b0);
    chk("rst_v", V, 1'b0);
    chk("rst16_in_ready", ir2, 1'b1);
    chk("rst16_s", s2, 16'h0000);
    @(negedge CLK);
    RST_N = 1'b1;
    mon_en = 1'b1;

    op(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b1, 0);
    op(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b1, 0);
    op(16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b1, 0);
    op(16'h7FFF, 16'h0001, 1'b0, SAT ? 16'h7FFF : 16'h8000, 1'b0, 1'b1, 1'b1, 0);
    op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 5);
    op(16'h8000, 16'h0001, 1'b1, SAT ? 16'h8000 : 16'h7FFF, 1'b1, 1'b1, 1'b1, 0);
    op(16'h8000, 16'h8000, 1'b0, SAT ? 16'h8000 : 16'h0000, 1'b1, 1'b1, 1'b1, 1);
    op(16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 0);
    op(16'h1234, 16'h0FED, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 0);
    op(16'hA5A5, 16'h5A5B, 1'b1, 16'h0, 1'b0, 1'b0, 1'b0, 2);
    op(16'h4000, 16'h4000, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 0);
    op(16'h8001, 16'h7FFF, 1'b1, 16'h0, 1'b0, 1'b0, 1'b0, 0);

    op16(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);
    op16(16'h7FFF, 16'h0001, 1'b0, SAT ? 16'h7FFF : 16'h8000, 1'b0, 1'b1);

    // Abandon an operation with reset during its second RUN cycle.
    @(negedge CLK);
    A = 16'h0001; B = 16'h0001; M = 1'b0; IN_VALID = 1'b1;
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b0;
    mon_en = 1'b0;
    @(posedge CLK); #1;
    chk("midrst_in_ready", IN_READY, 1'b1);
    chk("midrst_out_valid", OUT_VALID, 1'b0);
    chk("midrst_s", S, 16'h0000);
    chk("midrst_cout", Cout, 1'b0);
    @(negedge CLK);
    RST_N = 1'b1;
    shown_s = '0; shown_c = 1'b0; shown_v = 1'b0;
    mon_en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK);
      chk("midrst_no_result", OUT_VALID, 1'b0);
    end

    op(16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0, 1'b1, 0);

    @(negedge CLK);
    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
